// File: rtl/player_bullet_if.sv
// Bundle of the bullet manager's frame, player and collision-stage signals.
// The environment drives through master; the manager attaches through slave.
interface player_bullet_if #(
  parameter int MAX_PLAYER_BULLET = 8
);
  logic                             i_FrameTick;
  logic                             i_Fire;
  logic                             i_PlayerAlive;
  logic [9:0]                       i_PlayerX;
  logic [MAX_PLAYER_BULLET-1:0]     i_KillMask;
  logic [MAX_PLAYER_BULLET-1:0]     o_BulletState;
  logic [19*MAX_PLAYER_BULLET-1:0]  o_BulletPosition;
  logic                             o_FireAccepted;
  logic                             o_Full;

  modport master (
    output i_FrameTick, i_Fire, i_PlayerAlive, i_PlayerX, i_KillMask,
    input  o_BulletState, o_BulletPosition, o_FireAccepted, o_Full
  );

  modport slave (
    input  i_FrameTick, i_Fire, i_PlayerAlive, i_PlayerX, i_KillMask,
    output o_BulletState, o_BulletPosition, o_FireAccepted, o_Full
  );
endinterface

// File: rtl/player_bullet_manager.sv
// Player-bullet slot table: spawns on accepted fire, moves live bullets up once per frame,
// and retires them on leaving the top border or on a kill from the collision stage.
module player_bullet_manager #(
  parameter int          MAX_PLAYER_BULLET = 8,
  parameter int          BULLET_WIDTH      = 4,
  parameter int          BULLET_HEIGHT     = 8,
  parameter int          PLAYER_WIDTH      = 32,
  parameter int          PLAYER_Y          = 440,
  parameter int          MONITOR_WIDTH     = 640,
  parameter int          BULLET_SPEED      = 4,
  parameter int          FIRE_COOLDOWN     = 8,
  parameter logic [18:0] NONE              = 19'h7FFFF
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  player_bullet_if.slave bus
);

  localparam int N     = MAX_PLAYER_BULLET;
  // A zero cooldown still needs a one-bit counter so the register is never zero-width.
  localparam int CD_W  = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int X_MAX = MONITOR_WIDTH - BULLET_WIDTH;

  logic [N-1:0]         state_q, state_d;
  logic [N-1:0][18:0]   pos_q, pos_d;
  logic [CD_W-1:0]      cd_q, cd_d;
  logic                 acc_q, acc_d;

  logic                 free_found_s;
  logic [IDX_W-1:0]     free_idx_s;
  logic [10:0]          x_sum_s;
  logic [9:0]           x_spawn_s;
  logic                 spawn_s;

  // Lowest-index free slot in the registered state; scanning downward leaves the lowest one.
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!state_q[i]) begin
        free_found_s = 1'b1;
        free_idx_s   = IDX_W'(i);
      end else begin
        free_found_s = free_found_s;
      end
    end
  end

  // Spawn x is centred on the player and clamped so the bullet stays on screen.
  always_comb begin
    x_sum_s = {1'b0, bus.i_PlayerX} + 11'((PLAYER_WIDTH - BULLET_WIDTH) / 2);
    if (x_sum_s > 11'(X_MAX)) begin
      x_spawn_s = 10'(X_MAX);
    end else begin
      x_spawn_s = x_sum_s[9:0];
    end
  end

  assign spawn_s = bus.i_FrameTick & bus.i_Fire & bus.i_PlayerAlive &
                   (cd_q == '0) & free_found_s;

  // Next-state: kill, border retire and move per slot, then spawn into a slot that was free.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cd_d    = cd_q;
    acc_d   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (state_q[i] && bus.i_KillMask[i]) begin
        state_d[i] = 1'b0;
        pos_d[i]   = NONE;
      end else if (state_q[i] && bus.i_FrameTick) begin
        if (pos_q[i][8:0] < 9'(BULLET_SPEED)) begin
          state_d[i] = 1'b0;
          pos_d[i]   = NONE;
        end else begin
          pos_d[i][8:0] = pos_q[i][8:0] - 9'(BULLET_SPEED);
        end
      end else begin
        pos_d[i] = pos_q[i];
      end
      if (spawn_s && (free_idx_s == IDX_W'(i))) begin
        state_d[i] = 1'b1;
        pos_d[i]   = {x_spawn_s, 9'(PLAYER_Y - BULLET_HEIGHT)};
      end else begin
        state_d[i] = state_d[i];
      end
    end
    if (spawn_s) begin
      cd_d  = CD_W'(FIRE_COOLDOWN);
      acc_d = 1'b1;
    end else if (bus.i_FrameTick && (cd_q != '0)) begin
      cd_d = cd_q - CD_W'(1);
    end else begin
      cd_d = cd_q;
    end
  end

  // State register with immediate asynchronous clear.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= '0;
      pos_q   <= {N{NONE}};
      cd_q    <= '0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cd_q    <= cd_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.o_BulletState    = state_q;
  assign bus.o_BulletPosition = pos_q;
  assign bus.o_FireAccepted   = acc_q;
  assign bus.o_Full           = &state_q;

endmodule
